// File: rtl/vga_pkg.sv
// Shared constants for the 800x600@75 video path: timing, RGB565 colours,
// pattern mode encodings and the bouncing-box direction states.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 80;
    localparam int H_BACK   = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 600;
    localparam int V_FRONT  = 1;
    localparam int V_SYNC   = 3;
    localparam int V_BACK   = 21;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int BOX_SIZE = 64;
    localparam int STEP     = 2;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_GRID    = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    // Bit 1 set means moving left, bit 0 set means moving up.
    typedef enum logic [1:0] {
        RIGHT_DOWN = 2'b00,
        RIGHT_UP   = 2'b01,
        LEFT_DOWN  = 2'b10,
        LEFT_UP    = 2'b11
    } box_state_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = RGB_WHITE;
            3'd1:    bar_colour = RGB_YELLOW;
            3'd2:    bar_colour = RGB_CYAN;
            3'd3:    bar_colour = RGB_GREEN;
            3'd4:    bar_colour = RGB_MAGENTA;
            3'd5:    bar_colour = RGB_RED;
            3'd6:    bar_colour = RGB_BLUE;
            default: bar_colour = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_control_module_box.sv
// Bouncing-box position: advances STEP pixels per axis on each frame tick and
// reflects off the active-area edges, flipping direction bits at the limits.
module box_motion_module #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int BOX_SIZE = vga_pkg::BOX_SIZE,
    parameter int STEP     = vga_pkg::STEP
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o
);
    import vga_pkg::*;

    localparam logic [11:0] XMAX   = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] YMAX   = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] STEP_W = 12'(STEP);

    box_state_e  state_q;
    logic [11:0] x_q, y_q;
    logic        x_hit, y_hit;

    assign x_hit = state_q[1] ? (x_q <= STEP_W) : (x_q + STEP_W >= XMAX);
    assign y_hit = state_q[0] ? (y_q <= STEP_W) : (y_q + STEP_W >= YMAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RIGHT_DOWN;
            x_q     <= '0;
            y_q     <= '0;
        end else if (frame_tick_i) begin
            if (state_q[1]) x_q <= x_hit ? 12'd0 : x_q - STEP_W;
            else            x_q <= x_hit ? XMAX  : x_q + STEP_W;
            if (state_q[0]) y_q <= y_hit ? 12'd0 : y_q - STEP_W;
            else            y_q <= y_hit ? YMAX  : y_q + STEP_W;
            state_q <= box_state_e'({state_q[1] ^ x_hit, state_q[0] ^ y_hit});
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/vga_control_module.sv
// Test-pattern colour generator behind the sync generator: 2-stage pipeline
// producing RGB565 with HSYNC/VSYNC delayed to stay aligned with the pixels.
module vga_control_module #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int BOX_SIZE = vga_pkg::BOX_SIZE,
    parameter int STEP     = vga_pkg::STEP
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        Ready_Sig,
    input  logic [10:0] Column_Addr_Sig,
    input  logic [10:0] Row_Addr_Sig,
    input  logic        HSYNC_In,
    input  logic        VSYNC_In,
    input  logic [1:0]  Mode_Sel,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic [4:0]  Red_Sig,
    output logic [5:0]  Green_Sig,
    output logic [4:0]  Blue_Sig
);
    import vga_pkg::*;

    localparam int BAR_W = H_ACTIVE / 8;

    logic        ready_p1_q, hs_p1_q, vs_p1_q;
    logic [10:0] col_p1_q, row_p1_q;
    logic        frame_tick_q;
    mode_e       mode_q;
    logic [11:0] box_x, box_y, col_w, row_w;
    logic [2:0]  bar_idx;
    logic        grid_hit, box_hit, checker_bit;
    logic [15:0] rgb_d, rgb_p2_q;
    logic        hs_p2_q, vs_p2_q;

    box_motion_module #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)
    ) u_box (
        .clk_i       (CLK),
        .rst_ni      (RST_n),
        .frame_tick_i(frame_tick_q),
        .x_o         (box_x),
        .y_o         (box_y)
    );

    // Stage 1: capture pixel address and syncs; vs_p1_q doubles as the edge-detect delay.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ready_p1_q   <= 1'b0;
            hs_p1_q      <= 1'b1;
            vs_p1_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            mode_q       <= MODE_BARS;
        end else begin
            ready_p1_q   <= Ready_Sig;
            hs_p1_q      <= HSYNC_In;
            vs_p1_q      <= VSYNC_In;
            frame_tick_q <= vs_p1_q & ~VSYNC_In;
            if (frame_tick_q) mode_q <= mode_e'(Mode_Sel);
        end
    end

    always_ff @(posedge CLK) begin
        col_p1_q <= Column_Addr_Sig;
        row_p1_q <= Row_Addr_Sig;
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (col_p1_q >= 11'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    assign col_w       = {1'b0, col_p1_q};
    assign row_w       = {1'b0, row_p1_q};
    assign grid_hit    = (col_p1_q[5:0] == 6'd0) || (row_p1_q[5:0] == 6'd0);
    assign checker_bit = col_p1_q[5] ^ row_p1_q[5];
    assign box_hit     = (col_w >= box_x) && (col_w < box_x + 12'(BOX_SIZE)) &&
                         (row_w >= box_y) && (row_w < box_y + 12'(BOX_SIZE));

    always_comb begin
        rgb_d = RGB_BLACK;
        if (ready_p1_q) begin
            case (mode_q)
                MODE_BARS:    rgb_d = bar_colour(bar_idx);
                MODE_GRID:    rgb_d = grid_hit ? RGB_WHITE : RGB_BLACK;
                MODE_BOX:     rgb_d = box_hit ? RGB_RED : RGB_BLUE;
                MODE_CHECKER: rgb_d = checker_bit ? RGB_WHITE : RGB_BLACK;
                default:      rgb_d = RGB_BLACK;
            endcase
        end
    end

    // Stage 2: register the selected colour alongside the delayed syncs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rgb_p2_q <= RGB_BLACK;
            hs_p2_q  <= 1'b1;
            vs_p2_q  <= 1'b1;
        end else begin
            rgb_p2_q <= rgb_d;
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
        end
    end

    assign HSYNC_Sig = hs_p2_q;
    assign VSYNC_Sig = vs_p2_q;
    assign Red_Sig   = rgb_p2_q[15:11];
    assign Green_Sig = rgb_p2_q[10:5];
    assign Blue_Sig  = rgb_p2_q[4:0];

endmodule

// File: tb/tb_vga_control_module.sv
// Directed bench for vga_control_module: pipeline latency, patterns, mode
// latching, box bounce limits and asynchronous reset.
module tb_vga_control_module;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        Ready_Sig = 1'b0;
    logic [10:0] col = '0, row = '0;
    logic        hs_in = 1'b1, vs_in = 1'b1;
    logic [1:0]  mode_sel = 2'd0;
    logic        HSYNC_Sig, VSYNC_Sig;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic [15:0] rgb;
    int          checks = 0;
    int          errors = 0;

    assign rgb = {red, green, blue};

    vga_control_module dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .Ready_Sig      (Ready_Sig),
        .Column_Addr_Sig(col),
        .Row_Addr_Sig   (row),
        .HSYNC_In       (hs_in),
        .VSYNC_In       (vs_in),
        .Mode_Sel       (mode_sel),
        .HSYNC_Sig      (HSYNC_Sig),
        .VSYNC_Sig      (VSYNC_Sig),
        .Red_Sig        (red),
        .Green_Sig      (green),
        .Blue_Sig       (blue)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one pixel, then returns the RGB seen two clocks later.
    task automatic pix(input logic r, input int c, input int y, output logic [15:0] obs);
        Ready_Sig = r;
        col = 11'(c);
        row = 11'(y);
        step();
        Ready_Sig = 1'b0;
        step();
        obs = rgb;
    endtask

    task automatic frame_tick();
        vs_in = 1'b0;
        repeat (3) step();
        vs_in = 1'b1;
        repeat (2) step();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        mode_sel = 2'd3;
        step();
        checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL reset_rgb got %h want 0000", rgb); end
        checks++; if (HSYNC_Sig !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", HSYNC_Sig); end
        checks++; if (VSYNC_Sig !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", VSYNC_Sig); end
        RST_n = 1'b1;
        repeat (4) step();
        // Mode_Sel=3 must not be latched without a real VSYNC fall: still bars.
        pix(1'b1, 0, 0, obs);
        checks++; if (obs !== 16'hFFFF) begin errors++; $display("FAIL reset_no_tick got %h want FFFF", obs); end
        mode_sel = 2'd0;
    endtask

    task automatic test_latency();
        int          cols[10] = '{0, 99, 100, 199, 250, 350, 450, 550, 650, 799};
        logic [15:0] exp[10]  = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF,
                                  16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        row = 11'd0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                checks++;
                if (rgb !== exp[i-2]) begin
                    errors++;
                    $display("FAIL bars col=%0d got %h want %h", cols[i-2], rgb, exp[i-2]);
                end
            end
            if (i < 10) begin Ready_Sig = 1'b1; col = 11'(cols[i]); end
            else Ready_Sig = 1'b0;
            step();
        end
    endtask

    task automatic test_hsync();
        logic hv[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                checks++;
                if (HSYNC_Sig !== hv[i-2]) begin
                    errors++;
                    $display("FAIL hsync_delay idx=%0d got %b want %b", i - 2, HSYNC_Sig, hv[i-2]);
                end
            end
            hs_in = (i < 6) ? hv[i] : 1'b1;
            step();
        end
    endtask

    task automatic test_blanking();
        logic [15:0] obs;
        pix(1'b1, 150, 0, obs);
        checks++; if (obs !== 16'hFFE0) begin errors++; $display("FAIL blank_ref got %h want FFE0", obs); end
        pix(1'b0, 150, 0, obs);
        checks++; if (obs !== 16'h0000) begin errors++; $display("FAIL blank got %h want 0000", obs); end
    endtask

    task automatic test_mode_latch();
        logic [15:0] obs;
        int          cx[4] = '{32, 0, 32, 0};
        int          cy[4] = '{0, 0, 32, 32};
        logic [15:0] ex[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        mode_sel = 2'd3;
        pix(1'b1, 0, 0, obs);
        checks++; if (obs !== 16'hFFFF) begin errors++; $display("FAIL latch_pre0 got %h want FFFF", obs); end
        pix(1'b1, 150, 10, obs);
        checks++; if (obs !== 16'hFFE0) begin errors++; $display("FAIL latch_pre1 got %h want FFE0", obs); end
        vs_in = 1'b0;
        step();
        checks++; if (VSYNC_Sig !== 1'b1) begin errors++; $display("FAIL vsync_d1 got %b want 1", VSYNC_Sig); end
        step();
        checks++; if (VSYNC_Sig !== 1'b0) begin errors++; $display("FAIL vsync_d2 got %b want 0", VSYNC_Sig); end
        step();
        vs_in = 1'b1;
        repeat (2) step();
        checks++; if (VSYNC_Sig !== 1'b1) begin errors++; $display("FAIL vsync_rise got %b want 1", VSYNC_Sig); end
        for (int i = 0; i < 4; i++) begin
            pix(1'b1, cx[i], cy[i], obs);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL checker (%0d,%0d) got %h want %h", cx[i], cy[i], obs, ex[i]);
            end
        end
    endtask

    task automatic test_grid();
        logic [15:0] obs;
        int          cx[3] = '{64, 65, 65};
        int          cy[3] = '{5, 128, 127};
        logic [15:0] ex[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        mode_sel = 2'd1;
        frame_tick();
        for (int i = 0; i < 3; i++) begin
            pix(1'b1, cx[i], cy[i], obs);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL grid (%0d,%0d) got %h want %h", cx[i], cy[i], obs, ex[i]);
            end
        end
    endtask

    // Ticks so far: 1 (mode latch) + 1 (grid); the mode-2 tick makes 3 -> box at (6,6).
    task automatic test_box();
        logic [15:0] obs;
        int          ax[6] = '{6, 5, 6, 69, 70, 6};
        int          ay[6] = '{6, 6, 5, 69, 6, 70};
        logic [15:0] ae[6] = '{16'hF800, 16'h001F, 16'h001F, 16'hF800, 16'h001F, 16'h001F};
        int          bx[4] = '{536, 536, 599, 535};
        int          by[4] = '{536, 535, 599, 599};
        logic [15:0] be[4] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F};
        int          cx[4] = '{538, 537, 538, 538};
        int          cy[4] = '{534, 534, 597, 598};
        logic [15:0] ce[4] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F};
        int          dx[4] = '{736, 735, 799, 799};
        int          dy[4] = '{336, 336, 399, 400};
        logic [15:0] de[4] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F};
        int          fx[4] = '{734, 733, 797, 798};
        int          fy[4] = '{334, 334, 334, 334};
        logic [15:0] fe[4] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F};
        mode_sel = 2'd2;
        frame_tick();
        for (int i = 0; i < 6; i++) begin
            pix(1'b1, ax[i], ay[i], obs);
            checks++;
            if (obs !== ae[i]) begin errors++; $display("FAIL box_t3 (%0d,%0d) got %h want %h", ax[i], ay[i], obs, ae[i]); end
        end
        run_ticks(265);
        for (int i = 0; i < 4; i++) begin
            pix(1'b1, bx[i], by[i], obs);
            checks++;
            if (obs !== be[i]) begin errors++; $display("FAIL box_t268 (%0d,%0d) got %h want %h", bx[i], by[i], obs, be[i]); end
        end
        run_ticks(1);
        for (int i = 0; i < 4; i++) begin
            pix(1'b1, cx[i], cy[i], obs);
            checks++;
            if (obs !== ce[i]) begin errors++; $display("FAIL box_t269 (%0d,%0d) got %h want %h", cx[i], cy[i], obs, ce[i]); end
        end
        run_ticks(99);
        for (int i = 0; i < 4; i++) begin
            pix(1'b1, dx[i], dy[i], obs);
            checks++;
            if (obs !== de[i]) begin errors++; $display("FAIL box_t368 (%0d,%0d) got %h want %h", dx[i], dy[i], obs, de[i]); end
        end
        run_ticks(1);
        for (int i = 0; i < 4; i++) begin
            pix(1'b1, fx[i], fy[i], obs);
            checks++;
            if (obs !== fe[i]) begin errors++; $display("FAIL box_t369 (%0d,%0d) got %h want %h", fx[i], fy[i], obs, fe[i]); end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] obs;
        int          gx[5] = '{2, 1, 65, 66, 2};
        int          gy[5] = '{2, 2, 65, 2, 66};
        logic [15:0] ge[5] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F, 16'h001F};
        hs_in = 1'b0;
        Ready_Sig = 1'b1;
        col = 11'd734;
        row = 11'd334;
        repeat (2) step();
        checks++; if (rgb !== 16'hF800) begin errors++; $display("FAIL arst_pre_rgb got %h want F800", rgb); end
        checks++; if (HSYNC_Sig !== 1'b0) begin errors++; $display("FAIL arst_pre_hs got %b want 0", HSYNC_Sig); end
        #3 RST_n = 1'b0;
        #1;
        checks++; if (rgb !== 16'h0000) begin errors++; $display("FAIL arst_rgb got %h want 0000", rgb); end
        checks++; if (HSYNC_Sig !== 1'b1) begin errors++; $display("FAIL arst_hs got %b want 1", HSYNC_Sig); end
        Ready_Sig = 1'b0;
        hs_in = 1'b1;
        repeat (2) step();
        RST_n = 1'b1;
        repeat (2) step();
        pix(1'b1, 0, 0, obs);
        checks++; if (obs !== 16'hFFFF) begin errors++; $display("FAIL arst_mode got %h want FFFF", obs); end
        frame_tick();
        for (int i = 0; i < 5; i++) begin
            pix(1'b1, gx[i], gy[i], obs);
            checks++;
            if (obs !== ge[i]) begin errors++; $display("FAIL arst_box (%0d,%0d) got %h want %h", gx[i], gy[i], obs, ge[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hsync();
        test_blanking();
        test_mode_latch();
        test_grid();
        test_box();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
